// File: rtl/fptr_fifo_mgr.sv
// +--------------------------------------------------------------------+
// | fptr_fifo_mgr : free-pointer pool (circular FIFO) for packet memory |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fptr_fifo_mgr #(
  parameter int          PTR_WID = 9,
  parameter int unsigned LOW_WM  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_wen,
  input  logic [PTR_WID-1:0] init_wdata,
  input  logic               init_done,
  input  logic               alloc_req,
  output logic               alloc_ack,
  output logic [PTR_WID-1:0] alloc_ptr,
  input  logic               rel_wen,
  input  logic [PTR_WID-1:0] rel_ptr,
  output logic [PTR_WID:0]   free_cnt,
  output logic               fptr_empty,
  output logic               fptr_low,
  output logic               err_ovf,
  output logic               err_udf,
  output logic               err_proto
);

  localparam int DEPTH = 1 << PTR_WID;

  logic [PTR_WID-1:0] mem [DEPTH];
  logic [PTR_WID:0]   wr_ptr;
  logic [PTR_WID:0]   rd_ptr;

  logic               full;
  logic               wr_sel;
  logic [PTR_WID-1:0] wr_data;
  logic               wr_ok;
  logic               grant;
  logic               proto_viol;

  // Wrap bit distinguishes full from empty when the indices coincide.
  assign full       = (wr_ptr[PTR_WID] != rd_ptr[PTR_WID]) &&
                      (wr_ptr[PTR_WID-1:0] == rd_ptr[PTR_WID-1:0]);
  assign fptr_empty = (wr_ptr == rd_ptr);
  assign free_cnt   = wr_ptr - rd_ptr;
  assign fptr_low   = (32'(free_cnt) <= LOW_WM);

  assign wr_sel     = init_done ? rel_wen : init_wen;
  assign wr_data    = init_done ? rel_ptr : init_wdata;
  assign wr_ok      = wr_sel && !full;
  assign grant      = init_done && alloc_req && !fptr_empty;
  assign proto_viol = (!init_done && rel_wen) || (init_done && init_wen);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[PTR_WID-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      alloc_ack <= 1'b0;
      alloc_ptr <= '0;
      err_ovf   <= 1'b0;
      err_udf   <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      alloc_ack <= grant;
      if (grant) begin
        alloc_ptr <= mem[rd_ptr[PTR_WID-1:0]];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // Full-check uses pre-edge state even when a pop happens this cycle.
      if (wr_sel && full) begin
        err_ovf <= 1'b1;
      end
      if (grant && fptr_empty) begin
        err_udf <= 1'b1;
      end
      if (proto_viol) begin
        err_proto <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fptr_fifo_mgr.sv
// tb_fptr_fifo_mgr : directed + randomized checks against a queue-based pool model.
`default_nettype none

module tb_fptr_fifo_mgr;

  localparam int PW    = 4;
  localparam int DEPTH = 16;
  localparam int LWM   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_wen = 1'b0;
  logic [PW-1:0] init_wdata = '0;
  logic          init_done = 1'b0;
  logic          alloc_req = 1'b0;
  logic          alloc_ack;
  logic [PW-1:0] alloc_ptr;
  logic          rel_wen = 1'b0;
  logic [PW-1:0] rel_ptr = '0;
  logic [PW:0]   free_cnt;
  logic          fptr_empty;
  logic          fptr_low;
  logic          err_ovf;
  logic          err_udf;
  logic          err_proto;

  fptr_fifo_mgr #(.PTR_WID(PW), .LOW_WM(LWM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_wen   (init_wen),
    .init_wdata (init_wdata),
    .init_done  (init_done),
    .alloc_req  (alloc_req),
    .alloc_ack  (alloc_ack),
    .alloc_ptr  (alloc_ptr),
    .rel_wen    (rel_wen),
    .rel_ptr    (rel_ptr),
    .free_cnt   (free_cnt),
    .fptr_empty (fptr_empty),
    .fptr_low   (fptr_low),
    .err_ovf    (err_ovf),
    .err_udf    (err_udf),
    .err_proto  (err_proto)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the pool is a queue of pointers.
  logic [PW-1:0] q[$];
  logic          m_ack   = 1'b0;
  logic [PW-1:0] m_ptr   = '0;
  logic          m_ovf   = 1'b0;
  logic          m_proto = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_ack = 1'b0; m_ptr = '0; m_ovf = 1'b0; m_proto = 1'b0;
      end else begin
        int            pre;
        logic          wr;
        logic [PW-1:0] wd;
        pre = q.size();
        wr  = init_done ? rel_wen : init_wen;
        wd  = init_done ? rel_ptr : init_wdata;
        if ((!init_done && rel_wen) || (init_done && init_wen)) m_proto = 1'b1;
        if (init_done && alloc_req && pre > 0) begin
          m_ptr = q.pop_front();
          m_ack = 1'b1;
        end else begin
          m_ack = 1'b0;
        end
        if (wr) begin
          if (pre == DEPTH) m_ovf = 1'b1;
          else q.push_back(wd);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("free_cnt",   32'(free_cnt),   32'(q.size()));
      chk("fptr_empty", 32'(fptr_empty), 32'(q.size() == 0));
      chk("fptr_low",   32'(fptr_low),   32'(q.size() <= LWM));
      chk("alloc_ack",  32'(alloc_ack),  32'(m_ack));
      chk("alloc_ptr",  32'(alloc_ptr),  32'(m_ptr));
      chk("err_ovf",    32'(err_ovf),    32'(m_ovf));
      chk("err_udf",    32'(err_udf),    32'd0);
      chk("err_proto",  32'(err_proto),  32'(m_proto));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_free_cnt", 32'(free_cnt), 32'd0);
    chk("rst_empty",    32'(fptr_empty), 32'd1);
    chk("rst_low",      32'(fptr_low), 32'd1);
    rst_n = 1'b1;

    // Init fill 0..15
    for (int i = 0; i < DEPTH; i++) begin
      init_wen = 1'b1; init_wdata = PW'(i);
      step();
    end
    init_wen = 1'b0; init_done = 1'b1;
    step();
    chk("init_free_cnt", 32'(free_cnt), 32'd16);
    chk("init_errs", 32'({err_ovf, err_udf, err_proto}), 32'd0);

    // Allocation order: three back-to-back grants
    alloc_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("order_ack", 32'(alloc_ack), 32'd1);
      chk("order_ptr", 32'(alloc_ptr), 32'(i));
    end
    alloc_req = 1'b0;
    step();
    chk("order_ack_end", 32'(alloc_ack), 32'd0);
    chk("order_cnt", 32'(free_cnt), 32'd13);
    chk("order_low", 32'(fptr_low), 32'd0);

    // Drain and stall
    alloc_req = 1'b1;
    repeat (15) step();
    chk("drain_empty", 32'(fptr_empty), 32'd1);
    chk("drain_noack", 32'(alloc_ack), 32'd0);
    chk("drain_udf",   32'(err_udf), 32'd0);
    rel_wen = 1'b1; rel_ptr = 4'd7;
    step();
    rel_wen = 1'b0;
    chk("nobypass_ack", 32'(alloc_ack), 32'd0);
    step();
    chk("stall_ack", 32'(alloc_ack), 32'd1);
    chk("stall_ptr", 32'(alloc_ptr), 32'd7);
    alloc_req = 1'b0;

    // Simultaneous grant and release at free_cnt=5
    for (int i = 10; i < 15; i++) begin
      rel_wen = 1'b1; rel_ptr = PW'(i);
      step();
    end
    alloc_req = 1'b1; rel_ptr = 4'd9;
    step();
    alloc_req = 1'b0; rel_wen = 1'b0;
    chk("simul_ptr", 32'(alloc_ptr), 32'd10);
    chk("simul_cnt", 32'(free_cnt), 32'd5);
    chk("simul_tail", 32'(q[$]), 32'd9);

    // Overflow when full
    for (int i = 0; i < 11; i++) begin
      rel_wen = 1'b1; rel_ptr = PW'(i);
      step();
    end
    chk("full_cnt", 32'(free_cnt), 32'd16);
    rel_ptr = 4'd3;
    step();
    rel_wen = 1'b0;
    chk("ovf_flag", 32'(err_ovf), 32'd1);
    chk("ovf_cnt",  32'(free_cnt), 32'd16);
    alloc_req = 1'b1;
    step();
    chk("ovf_head", 32'(alloc_ptr), 32'd11);
    alloc_req = 1'b0;

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt",  32'(free_cnt), 32'd0);
    chk("arst_ack",  32'(alloc_ack), 32'd0);
    chk("arst_flags", 32'({err_ovf, err_udf, err_proto}), 32'd0);
    chk("arst_empty", 32'(fptr_empty), 32'd1);
    init_done = 1'b0;
    step();
    rst_n = 1'b1;

    // Release before init_done
    rel_wen = 1'b1; rel_ptr = 4'd5;
    step();
    rel_wen = 1'b0;
    chk("proto_rel", 32'(err_proto), 32'd1);
    chk("proto_cnt", 32'(free_cnt), 32'd0);

    // Randomized init then randomized traffic
    for (int i = 0; i < 24; i++) begin
      init_wen = ($urandom_range(0, 3) != 0);
      init_wdata = PW'($urandom);
      step();
    end
    init_wen = 1'b0; init_done = 1'b1;
    for (int i = 0; i < 600; i++) begin
      alloc_req = ($urandom_range(0, 1) == 1);
      rel_wen   = ($urandom_range(0, 99) < ((i / 150) % 2 == 0 ? 35 : 65));
      rel_ptr   = PW'($urandom);
      init_wen  = ($urandom_range(0, 199) == 0);
      step();
    end
    alloc_req = 1'b0; rel_wen = 1'b0; init_wen = 1'b0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fptr_fifo_mgr.md
Name: fptr_fifo_mgr

Overview:
- Free-pointer pool for the packet memory.
- Sits directly downstream of the free-pointer init stage. It absorbs that stage's write stream (pointers 0..2^PTR_WID-1) into an internal circular FIFO.
- After init it serves buffer allocation requests from the packet write path and takes pointer releases from the packet read path.
- Tracks free count, a low-watermark flag, and sticky overflow/underflow/protocol error flags.

Parameters:
- PTR_WID, 9, pointer width; pool depth DEPTH = 2^PTR_WID.
- LOW_WM, 16, fptr_low asserts when free_cnt <= LOW_WM.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- init_wen  input  1  init-stage write strobe.
- init_wdata  input  PTR_WID  init-stage pointer value.
- init_done  input  1  init stage finished; pool is usable.
- alloc_req  input  1  level request; one pointer is popped per granted cycle.
- alloc_ack  output  1  pulse; alloc_ptr is valid.
- alloc_ptr  output  PTR_WID  allocated pointer.
- rel_wen  input  1  release strobe.
- rel_ptr  input  PTR_WID  pointer being returned.
- free_cnt  output  PTR_WID+1  pointers currently in the pool.
- fptr_empty  output  1  free_cnt == 0.
- fptr_low  output  1  free_cnt <= LOW_WM.
- err_ovf  output  1  sticky: write attempted while full.
- err_udf  output  1  sticky: reserved for pop-while-empty (cannot occur by design, see below).
- err_proto  output  1  sticky: release before init_done, or init write after init_done.

Behaviour:
- Storage: DEPTH x PTR_WID register array. wr_ptr and rd_ptr are each PTR_WID+1 bits. The MSB is the wrap bit. Full when the indices are equal and the MSBs differ; empty when the pointers are fully equal.
- free_cnt = wr_ptr - rd_ptr, modulo 2^(PTR_WID+1). Range is 0..DEPTH.
- Reset (async, rst_n=0):
  - pointers cleared; free_cnt=0.
  - alloc_ack=0, alloc_ptr=0.
  - all err flags 0; fptr_empty=1, fptr_low=1.
  - Array contents are don't-care.
- Write source select:
  - While init_done=0: only init_wen writes, and rel_wen is ignored. If rel_wen=1 in this phase, err_proto sets.
  - While init_done=1: only rel_wen writes, and init_wen is ignored. If init_wen=1 in this phase, err_proto sets.
- Write: if the selected strobe is high and the FIFO is not full, store the data at wr_ptr and increment wr_ptr. If the FIFO is full, drop the write, set err_ovf, and leave the pointers unchanged.
- Grant condition: init_done=1 && alloc_req=1 && !fptr_empty, all sampled at the clock edge.
  - On grant: alloc_ptr <= mem[rd_ptr]; rd_ptr increments.
  - alloc_ack=1 in the cycle after the grant edge (1-cycle latency).
  - Without a grant, alloc_ack=0 and alloc_ptr holds its last value.
- Ungranted alloc_req: the request stalls with no ack, and no error flag is set. Because of this, err_udf never sets by design; its presence as a sticky output is defined.
- Throughput: one grant per cycle while alloc_req stays high and the pool is non-empty.
- Simultaneous grant and write in one cycle: both take effect and free_cnt is unchanged.
  - When empty: no bypass. The pointer released this cycle is grantable from the next cycle on.
  - When full: the release is still dropped with err_ovf, based on pre-edge state. A duplicate release is an upstream bug regardless of the concurrent pop.
- fptr_empty, fptr_low and free_cnt are combinational from the registered pointers, so they reflect state after the last edge.
- Sticky errors clear only on reset.
- Reset mid-operation clears everything. The upstream init stage re-runs, and outstanding allocated pointers are considered lost.

Test Plan:
- Init fill (PTR_WID=4): drive 16 init writes 0..15, then raise init_done -> free_cnt=16, fptr_low=1 (LOW_WM=16), no errors.
- Allocation order (PTR_WID=4, LOW_WM=4): hold alloc_req for 3 cycles after init -> alloc_ack pulses in 3 consecutive cycles, starting 1 cycle after the first grant edge, with alloc_ptr=0,1,2; free_cnt=13; fptr_low=0.
- Drain and stall: allocate all 16, keep alloc_req high -> fptr_empty=1, no further ack, err_udf=0; then rel_ptr=7 -> ack on the following grant with alloc_ptr=7.
- Simultaneous grant and release at free_cnt=5: free_cnt stays 5; alloc_ptr is the oldest entry; the released pointer is appended at the tail.
- Overflow: with the pool full, pulse rel_wen with rel_ptr=3 -> err_ovf=1, free_cnt stays 16, contents unchanged.
- Protocol and reset:
  - rel_wen before init_done -> err_proto=1.
  - Assert rst_n low mid-stream -> free_cnt=0, alloc_ack=0, and all flags cleared asynchronously.
